pattern_bist: RTL and testbench
===============================

PATTERN_BIST -- requirements
Module: pattern_bist

Interface
REQ-001 Parameter WIDTH, default 8: stimulus, response and signature width in bits.
REQ-002 Parameter CNT_W, default 8: width of the pattern count.
REQ-003 Parameter TAPS, default 8'hB8: Galois feedback mask shared by the LFSR and the MISR.
REQ-004 Parameter RST_CYC, default 2: number of cycles the DUT is held in reset before patterns are applied (at least 1).
REQ-005 Parameter LAT, default 1: DUT response latency in cycles from a pat cycle to its dut_out cycle (at least 1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  begin a run; sampled only in IDLE or DONE.
REQ-009 seed  in  WIDTH  LFSR seed, latched on an accepted start.
REQ-010 num_pat  in  CNT_W  number of patterns to apply, latched on an accepted start.
REQ-011 hold  in  1  stall pattern issue during RUN.
REQ-012 dut_out  in  WIDTH  DUT response.
REQ-013 dut_rst  out  1  reset output driven to the DUT.
REQ-014 pat  out  WIDTH  stimulus to the DUT.
REQ-015 pat_valid  out  1  pat is a counted pattern this cycle.
REQ-016 busy  out  1  high in DUT_RST, RUN and FLUSH.
REQ-017 done  out  1  high while in DONE.
REQ-018 signature  out  WIDTH  MISR contents.

Function
REQ-019 FSM states: IDLE, DUT_RST, RUN, FLUSH, DONE.
REQ-020 start in IDLE or DONE:
- go to DUT_RST;
- latch num_pat;
- load LFSR with seed, or with 1 if seed is 0;
- clear the MISR and the valid pipeline.
REQ-021 start is ignored while busy.
REQ-022 DUT_RST lasts exactly RST_CYC cycles with dut_rst=1; it then goes to RUN, or to FLUSH if the latched count is 0.
REQ-023 RUN:
- pat = LFSR value and pat_valid = !hold;
- on each edge with pat_valid=1: LFSR advances and the count decrements;
- the edge that issues the last pattern moves the FSM to FLUSH.
REQ-024 Outside RUN: pat=0 and pat_valid=0.
REQ-025 LFSR step: next = (q >> 1) XOR (q[0] ? TAPS : 0).
REQ-026 pat_valid is delayed through a LAT-stage pipeline; on each edge where the delayed valid is 1, the MISR updates: sig = (sig >> 1) XOR (sig[0] ? TAPS : 0) XOR dut_out.
REQ-027 FLUSH lasts exactly LAT cycles and then goes to DONE, so every issued pattern's response is captured.
REQ-028 DONE holds signature and done=1 until the next start.
REQ-029 hold has no effect outside RUN; the delayed-valid pipeline keeps shifting while hold=1.

Reset
REQ-030 On reset:
- state=IDLE;
- LFSR=1, MISR=0, count=0, pipeline=0;
- dut_rst=1, all other outputs 0.
REQ-031 In IDLE, dut_rst=1.
REQ-032 Reset asserted mid-run aborts the run immediately; no partial signature is retained.

Configuration
REQ-033 Macro SIG_COMPARE_EN, when defined, adds:
- input golden (WIDTH): expected signature;
- output pass (1): registered, set on entry to DONE if signature equals golden, cleared on start and on reset.
REQ-034 Without SIG_COMPARE_EN, neither port exists and the behaviour is otherwise identical.

Verification (WIDTH=8, TAPS=8'hB8, RST_CYC=2, LAT=1)
REQ-035 Bench scenarios:
- Scenario 1: seed=8'h01, num_pat=6, hold=0 -> dut_rst high for 2 cycles; pat = 01, B8, 5C, 2E, 17, B3 on 6 consecutive cycles; done 1 cycle after the last pattern.
- Scenario 2: dut_out = pat registered one cycle, seed=8'h01, num_pat=3 -> signature=8'h5C; with SIG_COMPARE_EN and golden=8'h5C, pass=1.
- Scenario 3: seed=0, num_pat=2 -> pat = 01, B8, identical to seed=8'h01.
- Scenario 4: num_pat=0 -> DUT_RST, then FLUSH, then DONE; pat_valid never high; signature=0.
- Scenario 5: hold high for 3 cycles mid-run with num_pat=6 -> same 6-value pat sequence with a 3-cycle gap; same signature as the unheld run.
- Scenario 6: reset pulsed during RUN, and start pulsed during RUN -> reset returns to IDLE with signature=0; start during RUN is ignored.

Source files
------------

// File: rtl/pattern_bist.sv
// LFSR-driven BIST sequencer: resets the DUT, applies pseudo-random patterns and folds responses into a MISR.
// Optional macro SIG_COMPARE_EN adds a golden-signature input and a registered pass flag.
module pattern_bist #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       CNT_W   = 8,
    parameter logic [WIDTH-1:0]  TAPS    = WIDTH'(8'hB8),
    parameter int unsigned       RST_CYC = 2,
    parameter int unsigned       LAT     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             hold,
    input  logic [WIDTH-1:0] dut_out,
`ifdef SIG_COMPARE_EN
    input  logic [WIDTH-1:0] golden,
    output logic             pass,
`endif
    output logic             dut_rst,
    output logic [WIDTH-1:0] pat,
    output logic             pat_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature
);

    localparam int unsigned MAXC = (RST_CYC > LAT) ? RST_CYC : LAT;
    localparam int unsigned TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [CNT_W-1:0] cnt;
    logic [TW-1:0]    tmr;
    logic [LAT-1:0]   vp;
    logic [LAT-1:0]   vp_nxt;
    logic [WIDTH-1:0] misr_nxt;

    // Galois shift shared by the pattern generator and the signature register
    function automatic logic [WIDTH-1:0] gstep(input logic [WIDTH-1:0] q);
        return (q >> 1) ^ (q[0] ? TAPS : '0);
    endfunction

    // Pattern outputs follow hold within the same cycle; the MISR folds in delayed responses
    always_comb begin
        pat_valid = 1'b0;
        pat       = '0;
        if (state == RUN) begin
            pat_valid = !hold;
            pat       = lfsr;
        end
        vp_nxt   = (vp << 1) | LAT'(pat_valid);
        misr_nxt = vp[LAT-1] ? (gstep(signature) ^ dut_out) : signature;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= WIDTH'(1);
            cnt       <= '0;
            tmr       <= '0;
            vp        <= '0;
            signature <= '0;
            dut_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SIG_COMPARE_EN
            pass      <= 1'b0;
`endif
        end else begin
            vp        <= vp_nxt;
            signature <= misr_nxt;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DUT_RST;
                        cnt       <= num_pat;
                        lfsr      <= (seed == '0) ? WIDTH'(1) : seed;
                        vp        <= '0;
                        signature <= '0;
                        tmr       <= TW'(RST_CYC - 1);
                        dut_rst   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef SIG_COMPARE_EN
                        pass      <= 1'b0;
`endif
                    end
                end
                DUT_RST: begin
                    if (tmr == '0) begin
                        dut_rst <= 1'b0;
                        if (cnt == '0) begin
                            state <= FLUSH;
                            tmr   <= TW'(LAT - 1);
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                RUN: begin
                    if (pat_valid) begin
                        lfsr <= gstep(lfsr);
                        cnt  <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= FLUSH;
                            tmr   <= TW'(LAT - 1);
                        end
                    end
                end
                FLUSH: begin
                    // Last flush edge also captures the final response, so compare the incoming value
                    if (tmr == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SIG_COMPARE_EN
                        pass  <= (misr_nxt == golden);
`endif
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_bist.sv
// Scoreboard bench for pattern_bist: expected patterns/signatures queued at stimulus, checked by a monitor.
module tb_pattern_bist;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RST_CYC = 2;
    localparam int unsigned LAT     = 1;
    localparam logic [7:0]  TAPS    = 8'hB8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] num_pat;
    logic             hold;
    logic [WIDTH-1:0] dut_out;
    logic             dut_rst;
    logic [WIDTH-1:0] pat;
    logic             pat_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] signature;
`ifdef SIG_COMPARE_EN
    logic [WIDTH-1:0] golden;
    logic             pass;
`endif

    pattern_bist #(
        .WIDTH(WIDTH), .CNT_W(CNT_W), .TAPS(TAPS), .RST_CYC(RST_CYC), .LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .seed(seed),
        .num_pat(num_pat),
        .hold(hold),
        .dut_out(dut_out),
`ifdef SIG_COMPARE_EN
        .golden(golden),
        .pass(pass),
`endif
        .dut_rst(dut_rst),
        .pat(pat),
        .pat_valid(pat_valid),
        .busy(busy),
        .done(done),
        .signature(signature)
    );

    always #5 clk = ~clk;

    // Behavioural DUT: registered pattern, optionally scrambled by a constant mask
    logic [WIDTH-1:0] mask = '0;
    always @(posedge clk) dut_out <= pat ^ mask;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] pat_q[$];
    logic [WIDTH-1:0] sig_q[$];
    logic [WIDTH-1:0] lit_q[$];
    logic             sig_lit_en = 1'b0;
    logic [WIDTH-1:0] sig_lit    = '0;
    logic             done_d     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] gal(input logic [WIDTH-1:0] q);
        return (q >> 1) ^ (q[0] ? TAPS : 8'h00);
    endfunction

    // Monitor: every presented pattern and every completed signature is checked against the queues
    always @(negedge clk) begin
        if (!reset) begin
            if (pat_valid) begin
                if (pat_q.size() == 0) chk("unexpected_pat_valid", 32'(pat_valid), 32'd0);
                else                   chk("pat", 32'(pat), 32'(pat_q.pop_front()));
            end
            if (done && !done_d) begin
                if (sig_q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
                else begin
                    logic [WIDTH-1:0] e;
                    e = sig_q.pop_front();
                    chk("signature", 32'(signature), 32'(e));
`ifdef SIG_COMPARE_EN
                    chk("pass", 32'(pass), 32'(e == golden));
`endif
                end
            end
        end
        done_d = done;
    end

    // Queue expectations for a run and launch it; returns the model signature
    task automatic launch(input logic [WIDTH-1:0] s, input int n, input logic [WIDTH-1:0] m,
                          input logic bad_golden, output logic [WIDTH-1:0] sig);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] p;
        q   = (s == 8'h00) ? 8'h01 : s;
        sig = 8'h00;
        for (int i = 0; i < n; i++) begin
            p   = (lit_q.size() > 0) ? lit_q[i] : q;
            pat_q.push_back(p);
            sig = gal(sig) ^ (p ^ m);
            q   = gal(q);
        end
        if (sig_lit_en) sig = sig_lit;
        sig_q.push_back(sig);
        lit_q.delete();
        sig_lit_en = 1'b0;
`ifdef SIG_COMPARE_EN
        golden = bad_golden ? (sig ^ 8'h01) : sig;
`else
        if (bad_golden) sig = sig;
`endif
        mask    = m;
        seed    = s;
        num_pat = CNT_W'(n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        seed    = 8'($urandom);
        num_pat = 8'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run(input logic [WIDTH-1:0] s, input int n, input logic [WIDTH-1:0] m,
                       input int hold_at, input int hold_len, input int start_at, input logic bad_golden);
        logic [WIDTH-1:0] sig;
        int c;
        launch(s, n, m, bad_golden, sig);
        c = 0;
        while (dut_rst && c < 20) begin c++; tick(); end
        chk("dut_rst_cycles", 32'(c), 32'(RST_CYC));
        c = 0;
        while (!done && c < 400) begin
            hold  = (c >= hold_at) && (c < hold_at + hold_len);
            start = (c == start_at);
            tick();
            c++;
        end
        hold  = 1'b0;
        start = 1'b0;
        chk("run_cycles", 32'(c), 32'(n + ((n > 0) ? hold_len : 0) + int'(LAT)));
        chk("done", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("pats_all_issued", 32'(pat_q.size()), 32'd0);
        tick();
        tick();
        chk("sig_held", 32'(signature), 32'(sig));
        chk("done_held", 32'(done), 32'd1);
        chk("sig_checked", 32'(sig_q.size()), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] sig;
        int n;
        int ha;
        reset   = 1'b1;
        start   = 1'b0;
        hold    = 1'b0;
        seed    = '0;
        num_pat = '0;
`ifdef SIG_COMPARE_EN
        golden  = '0;
`endif
        tick();
        tick();
        chk("rst_dut_rst", 32'(dut_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);
        chk("rst_pat_valid", 32'(pat_valid), 32'd0);
        chk("rst_pat", 32'(pat), 32'd0);
        reset = 1'b0;
        hold  = 1'b1;
        tick();
        tick();
        chk("idle_dut_rst", 32'(dut_rst), 32'd1);
        chk("idle_hold_no_effect", 32'(pat_valid), 32'd0);
        hold = 1'b0;

        lit_q = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        run(8'h01, 6, 8'h00, 1000, 0, -1, 1'b0);

        lit_q = '{8'h01, 8'hB8, 8'h5C};
        sig_lit_en = 1'b1; sig_lit = 8'h5C;
        run(8'h01, 3, 8'h00, 1000, 0, -1, 1'b0);

        lit_q = '{8'h01, 8'hB8};
        run(8'h00, 2, 8'h00, 1000, 0, -1, 1'b0);

        sig_lit_en = 1'b1; sig_lit = 8'h00;
        run(8'h5A, 0, 8'h3C, 1000, 0, -1, 1'b0);

        run(8'h01, 6, 8'h00, 2, 3, -1, 1'b0);
        run(8'h01, 6, 8'h00, 1000, 0, 3, 1'b0);
        run(8'h01, 4, 8'h00, 1000, 0, -1, 1'b1);

        // Mid-run reset discards the run entirely
        launch(8'h33, 6, 8'h00, 1'b0, sig);
        for (int i = 0; i < RST_CYC + 3; i++) tick();
        chk("midrun_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_sig", 32'(signature), 32'd0);
        chk("midrun_rst_dut_rst", 32'(dut_rst), 32'd1);
        chk("midrun_rst_pat_valid", 32'(pat_valid), 32'd0);
        chk("midrun_rst_done", 32'(done), 32'd0);
        pat_q.delete();
        sig_q.delete();
        tick();
        reset = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) begin
            n  = int'($urandom_range(0, 20));
            ha = (n > 0) ? int'($urandom_range(0, n - 1)) : 1000;
            run(8'($urandom), n, 8'($urandom), ha, int'($urandom_range(0, 4)),
                int'($urandom_range(0, 30)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
